truth_table_checker: RTL and testbench

Hardware response checker for single-output combinational blocks with 4 inputs. It sweeps the 16 input vectors {a,b,c,d} from 0000 to 1111, drives them to the block under test, and samples its output `f` after a programmable settle time. It builds the captured 16-entry truth table, compares it against an expected minterm mask, and reports pass/fail, the mismatch count and the first failing minterm. It sits on the receiving end of the exhaustive-sweep flow: it reads and judges the responses rather than only generating stimulus.

---
 rtl/truth_table_checker_if.sv | 25 ++
 rtl/truth_table_checker.sv | 132 +++++++++++++
 tb/tb_truth_table_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/truth_table_checker_if.sv
// Handshake and result bundle between a truth-table checker and whatever drives it.
// The checker side uses the slave modport; the stimulus/host side uses master.
interface truth_table_checker_if;
  logic        start;
  logic [15:0] expected;
  logic        f_in;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] captured;
  logic [4:0]  err_count;
  logic [3:0]  first_err;
  logic        first_err_valid;

  modport master (
    output start, expected, f_in,
    input  abcd, busy, done, pass, captured, err_count, first_err, first_err_valid
  );

  modport slave (
    input  start, expected, f_in,
    output abcd, busy, done, pass, captured, err_count, first_err, first_err_valid
  );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive 4-input response checker: sweeps abcd 0..15, samples f_in after SETTLE idle
// cycles per vector, and compares the captured truth table with a latched expected mask.
module truth_table_checker #(
  parameter int unsigned SETTLE = 2
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_checker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE);

  state_e      state_q, state_d;
  logic [15:0] exp_q, exp_d;
  logic [3:0]  abcd_q, abcd_d;
  logic [3:0]  settle_q, settle_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] captured_q, captured_d;
  logic [4:0]  err_count_q, err_count_d;
  logic [3:0]  first_err_q, first_err_d;
  logic        first_err_valid_q, first_err_valid_d;

  logic mismatch;
  logic sample;

  assign mismatch = bus.f_in ^ exp_q[abcd_q];
  assign sample   = (settle_q == SettleLast);

  always_comb begin
    state_d           = state_q;
    exp_d             = exp_q;
    abcd_d            = abcd_q;
    settle_d          = settle_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    pass_d            = pass_q;
    captured_d        = captured_q;
    err_count_d       = err_count_q;
    first_err_d       = first_err_q;
    first_err_valid_d = first_err_valid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d           = StRun;
          exp_d             = bus.expected;
          captured_d        = '0;
          err_count_d       = '0;
          first_err_d       = '0;
          first_err_valid_d = 1'b0;
          pass_d            = 1'b0;
          abcd_d            = '0;
          settle_d          = '0;
          busy_d            = 1'b1;
        end
      end
      StRun: begin
        if (!sample) begin
          settle_d = settle_q + 4'd1;
        end else begin
          settle_d           = '0;
          captured_d[abcd_q] = bus.f_in;
          if (mismatch) begin
            err_count_d = err_count_q + 5'd1;
            if (!first_err_valid_q) begin
              first_err_d       = abcd_q;
              first_err_valid_d = 1'b1;
            end
          end
          if (abcd_q == 4'hF) begin
            // Verdict uses the count including this final sample.
            state_d = StFinish;
            abcd_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == 5'd0);
          end else begin
            abcd_d = abcd_q + 4'd1;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      exp_q             <= '0;
      abcd_q            <= '0;
      settle_q          <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      captured_q        <= '0;
      err_count_q       <= '0;
      first_err_q       <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      exp_q             <= exp_d;
      abcd_q            <= abcd_d;
      settle_q          <= settle_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      captured_q        <= captured_d;
      err_count_q       <= err_count_d;
      first_err_q       <= first_err_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign bus.abcd            = abcd_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.captured        = captured_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err       = first_err_q;
  assign bus.first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: two checkers (SETTLE=2 and SETTLE=0) driven by small behavioural
// blocks under test, results compared against hand-computed truth tables.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst;
  logic mode;

  always #5 clk = ~clk;

  truth_table_checker_if if0 ();
  truth_table_checker_if if1 ();

  truth_table_checker #(.SETTLE(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  truth_table_checker #(.SETTLE(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // mode 1: f = (a & b) | (c & d); mode 0: f tied low.
  always_comb if0.f_in = mode ? ((if0.abcd[3] & if0.abcd[2]) | (if0.abcd[1] & if0.abcd[0]))
                              : 1'b0;
  always_comb if1.f_in = if1.abcd[0];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered on the negedge right after start acceptance; returns on the done negedge.
  task automatic wait_done0(output int lat, output logic steps_ok);
    lat      = 0;
    steps_ok = 1'b1;
    while (if0.done !== 1'b1 && lat < 200) begin
      if (if0.abcd !== 4'(lat / 3) || if0.busy !== 1'b1) steps_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  int   lat;
  logic ok;
  int   ndone;

  initial begin
    rst          = 1'b1;
    mode         = 1'b1;
    if0.start    = 1'b0;
    if0.expected = '0;
    if1.start    = 1'b0;
    if1.expected = '0;
    repeat (2) @(negedge clk);

    check("rst_abcd", 32'(if0.abcd), 32'h0);
    check("rst_busy", 32'(if0.busy), 32'h0);
    check("rst_done", 32'(if0.done), 32'h0);
    check("rst_pass", 32'(if0.pass), 32'h0);
    check("rst_captured", 32'(if0.captured), 32'h0);
    check("rst_err_count", 32'(if0.err_count), 32'h0);
    check("rst_first_err", 32'(if0.first_err), 32'h0);
    check("rst_first_err_valid", 32'(if0.first_err_valid), 32'h0);
    check("rst_busy_s0", 32'(if1.busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Model 1 against its exact truth table.
    if0.expected = 16'hF888;
    if0.start    = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0(lat, ok);
    check("m1_latency", 32'(lat), 32'd48);
    check("m1_steps", 32'(ok), 32'h1);
    check("m1_captured", 32'(if0.captured), 32'hF888);
    check("m1_pass", 32'(if0.pass), 32'h1);
    check("m1_err_count", 32'(if0.err_count), 32'h0);
    check("m1_first_err_valid", 32'(if0.first_err_valid), 32'h0);
    check("m1_busy_at_done", 32'(if0.busy), 32'h0);
    check("m1_abcd_at_done", 32'(if0.abcd), 32'h0);
    @(negedge clk);
    check("m1_done_pulse", 32'(if0.done), 32'h0);
    check("m1_pass_hold", 32'(if0.pass), 32'h1);

    // Single mismatch at minterm 0.
    if0.expected = 16'hF889;
    if0.start    = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0(lat, ok);
    check("m2_latency", 32'(lat), 32'd48);
    check("m2_pass", 32'(if0.pass), 32'h0);
    check("m2_err_count", 32'(if0.err_count), 32'd1);
    check("m2_first_err", 32'(if0.first_err), 32'h0);
    check("m2_first_err_valid", 32'(if0.first_err_valid), 32'h1);
    @(negedge clk);

    // All 16 minterms wrong: count must reach 16 without wrapping.
    mode         = 1'b0;
    if0.expected = 16'hFFFF;
    if0.start    = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0(lat, ok);
    check("z_captured", 32'(if0.captured), 32'h0);
    check("z_err_count", 32'(if0.err_count), 32'd16);
    check("z_first_err", 32'(if0.first_err), 32'h0);
    check("z_pass", 32'(if0.pass), 32'h0);
    @(negedge clk);

    // SETTLE=0 with f=d; a stray start mid-run must be ignored.
    if1.expected = 16'hAAAA;
    if1.start    = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    lat = 0;
    while (if1.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if1.start = (lat == 5);
    end
    if1.start = 1'b0;
    check("s0_latency", 32'(lat), 32'd16);
    check("s0_pass", 32'(if1.pass), 32'h1);
    check("s0_captured", 32'(if1.captured), 32'hAAAA);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (if1.done === 1'b1) ndone++;
    end
    check("s0_no_second_done", 32'(ndone), 32'd0);
    check("s0_idle_busy", 32'(if1.busy), 32'h0);

    // Reset mid-sweep at vector 7.
    mode         = 1'b1;
    if0.expected = 16'hF888;
    if0.start    = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (if0.abcd === 4'd7) break;
      @(negedge clk);
    end
    check("ab_reached7", 32'(if0.abcd), 32'd7);
    check("ab_live_captured", 32'(if0.captured), 32'h0008);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ab_abcd", 32'(if0.abcd), 32'h0);
    check("ab_busy", 32'(if0.busy), 32'h0);
    check("ab_captured", 32'(if0.captured), 32'h0);
    check("ab_err_count", 32'(if0.err_count), 32'h0);
    check("ab_first_err_valid", 32'(if0.first_err_valid), 32'h0);
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (if0.done === 1'b1) ndone++;
    end
    check("ab_no_done", 32'(ndone), 32'd0);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0(lat, ok);
    check("ab_rerun_latency", 32'(lat), 32'd48);
    check("ab_rerun_captured", 32'(if0.captured), 32'hF888);
    check("ab_rerun_pass", 32'(if0.pass), 32'h1);
    @(negedge clk);

    // Back-to-back with start held; expected changes during the first run.
    if0.expected = 16'hF888;
    if0.start    = 1'b1;
    @(negedge clk);
    if0.expected = 16'hF889;
    wait_done0(lat, ok);
    check("bb1_latency", 32'(lat), 32'd48);
    check("bb1_pass", 32'(if0.pass), 32'h1);
    @(negedge clk);
    check("bb_finish_busy", 32'(if0.busy), 32'h0);
    check("bb_finish_done", 32'(if0.done), 32'h0);
    @(negedge clk);
    check("bb2_accepted", 32'(if0.busy), 32'h1);
    if0.start = 1'b0;
    wait_done0(lat, ok);
    check("bb2_latency", 32'(lat), 32'd48);
    check("bb2_steps", 32'(ok), 32'h1);
    check("bb2_pass", 32'(if0.pass), 32'h0);
    check("bb2_err_count", 32'(if0.err_count), 32'd1);
    check("bb2_first_err", 32'(if0.first_err), 32'h0);
    check("bb2_first_err_valid", 32'(if0.first_err_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
